// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter for ALU/MEM/BR results
// Holds one result per FU and broadcasts at most one per cycle, squashing younger results on flush.
package cdb_pkg;
  parameter int XLEN   = 32;
  parameter int PREG_W = 7;
  parameter int TAG_W  = 5;

  typedef struct packed {
    logic              fu_alu_ready;
    logic [PREG_W-1:0] p_alu;
    logic              fu_alu_done;
    logic [TAG_W-1:0]  rob_fu_alu;
    logic [XLEN-1:0]   data;
  } alu_data;

  typedef struct packed {
    logic              fu_mem_ready;
    logic [PREG_W-1:0] p_mem;
    logic              fu_mem_done;
    logic [TAG_W-1:0]  rob_fu_mem;
    logic [XLEN-1:0]   data;
  } mem_data;

  typedef struct packed {
    logic              fu_b_ready;
    logic              br_taken;
    logic [PREG_W-1:0] p_b;
    logic              fu_b_done;
    logic [TAG_W-1:0]  rob_fu_b;
    logic [XLEN-1:0]   data;
  } b_data;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  alu_data           alu_in,
  input  mem_data           mem_in,
  input  b_data             br_in,
  output logic              alu_ready,
  output logic              mem_ready,
  output logic              br_ready,
  input  logic              flush,
  input  logic [TAG_W-1:0]  flush_tag,
  input  logic [TAG_W-1:0]  rob_head,
  output logic              cdb_valid,
  output logic              cdb_we,
  output logic [PREG_W-1:0] cdb_preg,
  output logic [XLEN-1:0]   cdb_data,
  output logic [TAG_W-1:0]  cdb_rob_tag,
  output logic [1:0]        cdb_src
);

  localparam int N = 3;

  logic [N-1:0]      in_done;
  logic [PREG_W-1:0] in_preg [N];
  logic [TAG_W-1:0]  in_tag  [N];
  logic [XLEN-1:0]   in_data [N];

  logic [N-1:0]      buf_valid;
  logic [PREG_W-1:0] buf_preg [N];
  logic [TAG_W-1:0]  buf_tag  [N];
  logic [XLEN-1:0]   buf_data [N];

  logic [1:0]   last_src;
  logic [1:0]   order [N];
  logic [N-1:0] squash_buf;
  logic [N-1:0] keep_in;
  logic [N-1:0] eligible;
  logic [N-1:0] grant;
  logic [N-1:0] ready;
  logic [N-1:0] accept;
  logic [1:0]   grant_idx;
  logic         grant_any;
  logic         unused_fields;

  // Ages are measured as distance from the ROB head so wrapped tags compare correctly.
  function automatic logic is_younger(input logic [TAG_W-1:0] t,
                                      input logic [TAG_W-1:0] head,
                                      input logic [TAG_W-1:0] ref_tag);
    logic [TAG_W-1:0] d_t;
    logic [TAG_W-1:0] d_ref;
    d_t   = t - head;
    d_ref = ref_tag - head;
    return d_t > d_ref;
  endfunction

  assign unused_fields = ^{alu_in.fu_alu_ready, mem_in.fu_mem_ready,
                           br_in.fu_b_ready, br_in.br_taken};

  always_comb begin
    in_done    = {br_in.fu_b_done, mem_in.fu_mem_done, alu_in.fu_alu_done};
    in_preg[0] = alu_in.p_alu;
    in_preg[1] = mem_in.p_mem;
    in_preg[2] = br_in.p_b;
    in_tag[0]  = alu_in.rob_fu_alu;
    in_tag[1]  = mem_in.rob_fu_mem;
    in_tag[2]  = br_in.rob_fu_b;
    in_data[0] = alu_in.data;
    in_data[1] = mem_in.data;
    in_data[2] = br_in.data;
  end

  always_comb begin
    squash_buf = '0;
    keep_in    = '1;
    for (int i = 0; i < N; i++) begin
      squash_buf[i] = flush && is_younger(buf_tag[i], rob_head, flush_tag);
      keep_in[i]    = !(flush && is_younger(in_tag[i], rob_head, flush_tag));
    end
    eligible = buf_valid & ~squash_buf;
  end

  // Round-robin walks downward from the last granted source: BR -> MEM -> ALU -> BR.
  always_comb begin
    case (last_src)
      2'd1:    begin order[0] = 2'd0; order[1] = 2'd2; order[2] = 2'd1; end
      2'd2:    begin order[0] = 2'd1; order[1] = 2'd0; order[2] = 2'd2; end
      default: begin order[0] = 2'd2; order[1] = 2'd1; order[2] = 2'd0; end
    endcase
  end

  always_comb begin
    grant_idx = 2'd0;
    grant_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[order[k]]) begin
        grant_idx = order[k];
        grant_any = 1'b1;
      end
    end
    grant = grant_any ? (3'b001 << grant_idx) : 3'b000;
  end

  assign ready     = ~buf_valid | grant;
  assign accept    = in_done & ready;
  assign alu_ready = ready[0];
  assign mem_ready = ready[1];
  assign br_ready  = ready[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid   <= '0;
      last_src    <= 2'd0;
      cdb_valid   <= 1'b0;
      cdb_we      <= 1'b0;
      cdb_preg    <= '0;
      cdb_data    <= '0;
      cdb_rob_tag <= '0;
      cdb_src     <= 2'd0;
      for (int i = 0; i < N; i++) begin
        buf_preg[i] <= '0;
        buf_tag[i]  <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        // An accepted younger result is consumed from the FU but never stored.
        if (accept[i]) begin
          buf_valid[i] <= keep_in[i];
          buf_preg[i]  <= in_preg[i];
          buf_tag[i]   <= in_tag[i];
          buf_data[i]  <= in_data[i];
        end else if (grant[i] || squash_buf[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end

      cdb_valid <= grant_any;
      cdb_we    <= grant_any && (buf_preg[grant_idx] != '0);
      if (grant_any) begin
        cdb_preg    <= buf_preg[grant_idx];
        cdb_data    <= buf_data[grant_idx];
        cdb_rob_tag <= buf_tag[grant_idx];
        cdb_src     <= grant_idx;
        last_src    <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic              clk;
  logic              reset;
  alu_data           alu_in;
  mem_data           mem_in;
  b_data             br_in;
  logic              alu_ready;
  logic              mem_ready;
  logic              br_ready;
  logic              flush;
  logic [TAG_W-1:0]  flush_tag;
  logic [TAG_W-1:0]  rob_head;
  logic              cdb_valid;
  logic              cdb_we;
  logic [PREG_W-1:0] cdb_preg;
  logic [XLEN-1:0]   cdb_data;
  logic [TAG_W-1:0]  cdb_rob_tag;
  logic [1:0]        cdb_src;

  int vectors;
  int miscompares;

  cdb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .alu_in     (alu_in),
    .mem_in     (mem_in),
    .br_in      (br_in),
    .alu_ready  (alu_ready),
    .mem_ready  (mem_ready),
    .br_ready   (br_ready),
    .flush      (flush),
    .flush_tag  (flush_tag),
    .rob_head   (rob_head),
    .cdb_valid  (cdb_valid),
    .cdb_we     (cdb_we),
    .cdb_preg   (cdb_preg),
    .cdb_data   (cdb_data),
    .cdb_rob_tag(cdb_rob_tag),
    .cdb_src    (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input int preg, input int tag, input logic [31:0] d);
    alu_in.fu_alu_done = 1'b1;
    alu_in.p_alu       = preg[PREG_W-1:0];
    alu_in.rob_fu_alu  = tag[TAG_W-1:0];
    alu_in.data        = d;
  endtask

  task automatic drive_mem(input int preg, input int tag, input logic [31:0] d);
    mem_in.fu_mem_done = 1'b1;
    mem_in.p_mem       = preg[PREG_W-1:0];
    mem_in.rob_fu_mem  = tag[TAG_W-1:0];
    mem_in.data        = d;
  endtask

  task automatic drive_br(input int preg, input int tag, input logic [31:0] d);
    br_in.fu_b_done = 1'b1;
    br_in.p_b       = preg[PREG_W-1:0];
    br_in.rob_fu_b  = tag[TAG_W-1:0];
    br_in.data      = d;
  endtask

  task automatic idle_all();
    alu_in.fu_alu_done = 1'b0;
    mem_in.fu_mem_done = 1'b0;
    br_in.fu_b_done    = 1'b0;
  endtask

  task automatic chk_readies(input string tag, input logic [2:0] exp_brmemalu);
    chk(tag, {61'd0, br_ready, mem_ready, alu_ready}, {61'd0, exp_brmemalu});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    flush       = 1'b0;
    flush_tag   = '0;
    rob_head    = '0;
    alu_in      = '0;
    mem_in      = '0;
    br_in       = '0;

    // reset held two cycles, then released
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", cdb_valid, 0);
    chk("rst_we", cdb_we, 0);
    chk("rst_preg", cdb_preg, 0);
    chk("rst_data", cdb_data, 0);
    chk("rst_tag", cdb_rob_tag, 0);
    chk("rst_src", cdb_src, 0);
    chk_readies("rst_ready", 3'b111);

    // single ALU result
    drive_alu(10, 3, 32'hDEADBEEF);
    tick();
    idle_all();
    #1;
    chk("alu1_c2_valid", cdb_valid, 0);
    tick();
    chk("alu1_valid", cdb_valid, 1);
    chk("alu1_we", cdb_we, 1);
    chk("alu1_preg", cdb_preg, 10);
    chk("alu1_tag", cdb_rob_tag, 3);
    chk("alu1_data", cdb_data, 32'hDEADBEEF);
    chk("alu1_src", cdb_src, 0);
    tick();
    chk("alu1_c4_valid", cdb_valid, 0);
    chk("alu1_c4_hold", cdb_data, 32'hDEADBEEF);

    // all three FUs done together
    drive_alu(11, 1, 32'h1111);
    drive_mem(12, 2, 32'h2222);
    drive_br(13, 3, 32'h3333);
    tick();
    idle_all();
    #1;
    chk("tri_c2_valid", cdb_valid, 0);
    chk_readies("tri_c2_ready", 3'b100);
    tick();
    chk("tri_c3_valid", cdb_valid, 1);
    chk("tri_c3_src", cdb_src, 2);
    chk("tri_c3_tag", cdb_rob_tag, 3);
    chk_readies("tri_c3_ready", 3'b110);
    tick();
    chk("tri_c4_src", cdb_src, 1);
    chk("tri_c4_tag", cdb_rob_tag, 2);
    chk("tri_c4_data", cdb_data, 32'h2222);
    chk_readies("tri_c4_ready", 3'b111);
    tick();
    chk("tri_c5_valid", cdb_valid, 1);
    chk("tri_c5_src", cdb_src, 0);
    chk("tri_c5_tag", cdb_rob_tag, 1);
    tick();
    chk("tri_c6_valid", cdb_valid, 0);

    // continuous done on all three: one grant per source every 3 cycles
    drive_alu(14, 4, 32'h4444);
    drive_mem(15, 5, 32'h5555);
    drive_br(16, 6, 32'h6666);
    #1;
    chk_readies("cont_d1_ready", 3'b111);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk_readies($sformatf("cont_ready_%0d", i), 3'b100 >> (i % 3));
      chk($sformatf("cont_valid_%0d", i), cdb_valid, (i > 0) ? 1 : 0);
      if (i > 0) begin
        chk($sformatf("cont_src_%0d", i), cdb_src, 2 - ((i - 1) % 3));
        chk($sformatf("cont_tag_%0d", i), cdb_rob_tag, 6 - ((i - 1) % 3));
      end
      tick();
    end
    idle_all();
    repeat (4) tick();
    chk("cont_drained", cdb_valid, 0);
    chk_readies("cont_drained_ready", 3'b111);

    // BR without destination register
    drive_br(0, 7, 32'h55);
    tick();
    idle_all();
    tick();
    chk("brx0_valid", cdb_valid, 1);
    chk("brx0_we", cdb_we, 0);
    chk("brx0_preg", cdb_preg, 0);
    chk("brx0_tag", cdb_rob_tag, 7);
    chk("brx0_src", cdb_src, 2);
    tick();

    // flush without wrap: head 0, branch tag 4
    drive_alu(20, 6, 32'hA6);
    drive_mem(21, 2, 32'hA2);
    tick();
    idle_all();
    drive_br(22, 5, 32'hB5);
    flush     = 1'b1;
    flush_tag = 5'd4;
    rob_head  = 5'd0;
    #1;
    chk_readies("fl_ready", 3'b110);
    tick();
    idle_all();
    flush = 1'b0;
    #1;
    chk("fl_valid", cdb_valid, 1);
    chk("fl_src", cdb_src, 1);
    chk("fl_tag", cdb_rob_tag, 2);
    chk("fl_data", cdb_data, 32'hA2);
    tick();
    chk("fl_after1_valid", cdb_valid, 0);
    chk_readies("fl_after_ready", 3'b111);
    tick();
    chk("fl_after2_valid", cdb_valid, 0);

    // flush with wrap: head 30, branch tag 1
    rob_head = 5'd30;
    drive_alu(23, 31, 32'h31);
    drive_mem(24, 2, 32'h02);
    tick();
    idle_all();
    flush     = 1'b1;
    flush_tag = 5'd1;
    #1;
    chk_readies("wr_ready", 3'b101);
    tick();
    flush = 1'b0;
    #1;
    chk("wr_valid", cdb_valid, 1);
    chk("wr_src", cdb_src, 0);
    chk("wr_tag", cdb_rob_tag, 31);
    tick();
    chk("wr_drop_valid", cdb_valid, 0);
    chk_readies("wr_drop_ready", 3'b111);
    tick();
    chk("wr_drop2_valid", cdb_valid, 0);

    // reset while all three buffers are full
    drive_alu(25, 8, 32'h88);
    drive_mem(26, 9, 32'h99);
    drive_br(27, 10, 32'hAA);
    tick();
    idle_all();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_valid", cdb_valid, 0);
    chk("mrst_data", cdb_data, 0);
    chk_readies("mrst_ready", 3'b111);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mrst_quiet_%0d", i), cdb_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
